// File: rtl/ram_pkg.sv
// ram_pkg: shared FSM state type and read latency helper for ram_sp
package ram_pkg;
  typedef enum logic {INIT, READY} state_t;
  function automatic int rd_latency(input bit out_reg);
    return out_reg ? 2 : 1;
  endfunction
endpackage

// File: rtl/ram_sp_core.sv
// ram_sp_core: byte-enabled storage array with first read register (clk, we, be, re, addr, din -> q)
module ram_sp_core #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  localparam int NBYTE = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NBYTE-1:0]  be,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < NBYTE; i++)
        if (be[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
    if (re) q <= mem[addr];
  end
endmodule

// File: rtl/ram_sp.sv
// ram_sp: single-port byte-enabled RAM with zero-fill after reset (clk, rst, cs_n, we_n, be_n, addr, din -> dout, dout_vld, busy)
module ram_sp
  import ram_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 1024,
  parameter int OUT_REG       = 0,
  parameter int INIT_ON_RESET = 1,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NBYTE  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              we_n,
  input  logic [NBYTE-1:0]  be_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              busy
);
  localparam int LAT = rd_latency(OUT_REG != 0);
  if (DATA_W % 8 != 0) begin : g_chk
    $error("DATA_W must be a multiple of 8");
  end
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [LAT-1:0] vld_q;
  logic in_range, acc, wr, rd, zero_q;
  logic [DATA_W-1:0] core_q, rd_data;
  assign busy = state == INIT;
  assign in_range = 32'(addr) < DEPTH;
  assign acc = state == READY && !cs_n && !rst;
  assign wr = acc && !we_n && in_range;
  assign rd = acc && we_n;
  always_comb state_nx = (state == INIT && 32'(cnt) == DEPTH - 1) ? READY : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INIT_ON_RESET != 0 ? INIT : READY;
      cnt    <= '0;
      vld_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= busy ? cnt + 1'b1 : '0;
      vld_q <= (vld_q << 1) | LAT'(rd);
      if (rd) zero_q <= !in_range;
    end
  end
  ram_sp_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_core (
    .clk (clk),
    .we  (busy || wr),
    .be  (busy ? {NBYTE{1'b1}} : ~be_n),
    .re  (rd && in_range),
    .addr(busy ? cnt : addr),
    .din (busy ? '0 : din),
    .q   (core_q)
  );
  // zero_q masks the untouched array register after reset and on out-of-range reads
  assign rd_data = zero_q ? '0 : core_q;
  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (rst) dout_q <= '0;
      else if (vld_q[0]) dout_q <= rd_data;
    end
    assign dout = dout_q;
  end else begin : g_noreg
    assign dout = rd_data;
  end
  assign dout_vld = vld_q[LAT-1];
endmodule

// File: tb/tb_ram_sp.sv
// tb_ram_sp: directed self-checking bench for ram_sp across three parameter sets
module tb_ram_sp;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  logic cs0_n = 1'b1, cs1_n = 1'b1, cs2_n = 1'b1, we_n = 1'b1;
  logic [3:0] be_n = 4'hF;
  logic [9:0] addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout0, dout1, dout2;
  logic vld0, vld1, vld2, busy0, busy1, busy2;
  int checks = 0, errors = 0;

  ram_sp u0 (.clk(clk), .rst(rst0), .cs_n(cs0_n), .we_n(we_n), .be_n(be_n), .addr(addr),
             .din(din), .dout(dout0), .dout_vld(vld0), .busy(busy0));
  ram_sp #(.DEPTH(1000), .OUT_REG(1)) u1 (.clk(clk), .rst(rst1), .cs_n(cs1_n), .we_n(we_n),
             .be_n(be_n), .addr(addr), .din(din), .dout(dout1), .dout_vld(vld1), .busy(busy1));
  ram_sp #(.DEPTH(64), .INIT_ON_RESET(0)) u2 (.clk(clk), .rst(rst2), .cs_n(cs2_n), .we_n(we_n),
             .be_n(be_n), .addr(addr[5:0]), .din(din), .dout(dout2), .dout_vld(vld2), .busy(busy2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input int inst, input logic wr, input logic [9:0] a, input logic [31:0] d,
                     input logic [3:0] be);
    cs0_n = inst != 0;
    cs1_n = inst != 1;
    cs2_n = inst != 2;
    we_n = !wr;
    addr = a;
    din = d;
    be_n = be;
    step();
    cs0_n = 1'b1;
    cs1_n = 1'b1;
    cs2_n = 1'b1;
    we_n = 1'b1;
  endtask

  task automatic test_reset();
    int n0 = 0, n1 = 0, n2 = 0;
    step();
    step();
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL reset_busy0 got %b exp 1", busy0); end
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL reset_vld0 got %b exp 0", vld0); end
    checks++; if (dout0 !== 32'h0) begin errors++; $display("FAIL reset_dout0 got %h exp 0", dout0); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL reset_busy1 got %b exp 1", busy1); end
    checks++; if (dout1 !== 32'h0) begin errors++; $display("FAIL reset_dout1 got %h exp 0", dout1); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2 got %b exp 0", busy2); end
    rst0 = 1'b0;
    rst1 = 1'b0;
    rst2 = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      if (busy2) n2++;
      step();
    end
    checks++; if (n0 != 1024) begin errors++; $display("FAIL fill_len0 got %0d exp 1024", n0); end
    checks++; if (n1 != 1000) begin errors++; $display("FAIL fill_len1 got %0d exp 1000", n1); end
    checks++; if (n2 != 0) begin errors++; $display("FAIL fill_len2 got %0d exp 0", n2); end
  endtask

  task automatic test_fill_read();
    acc(0, 1'b0, 10'h3FF, 32'h0, 4'hF);
    checks++; if (vld0 !== 1'b1 || dout0 !== 32'h0) begin errors++; $display("FAIL fill_read got vld=%b dout=%h exp vld=1 dout=0", vld0, dout0); end
    step();
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL fill_read_pulse got vld=%b exp 0", vld0); end
  endtask

  task automatic test_byte_lanes();
    acc(0, 1'b1, 10'h010, 32'hDEADBEEF, 4'b0000);
    acc(0, 1'b1, 10'h010, 32'h11223344, 4'b1010);
    acc(0, 1'b0, 10'h010, 32'h0, 4'hF);
    checks++; if (vld0 !== 1'b1 || dout0 !== 32'hDE22BE44) begin errors++; $display("FAIL byte_lanes got vld=%b dout=%h exp vld=1 dout=de22be44", vld0, dout0); end
    acc(0, 1'b1, 10'h010, 32'hFFFFFFFF, 4'hF);
    acc(0, 1'b0, 10'h010, 32'h0, 4'hF);
    checks++; if (dout0 !== 32'hDE22BE44) begin errors++; $display("FAIL no_lane_write got %h exp de22be44", dout0); end
  endtask

  task automatic test_raw();
    acc(0, 1'b1, 10'h020, 32'hCAFEF00D, 4'b0000);
    acc(0, 1'b0, 10'h020, 32'h0, 4'hF);
    checks++; if (vld0 !== 1'b1 || dout0 !== 32'hCAFEF00D) begin errors++; $display("FAIL raw got vld=%b dout=%h exp vld=1 dout=cafef00d", vld0, dout0); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] a [3] = '{10'h3FF, 10'h010, 10'h020};
    logic [31:0] e [3] = '{32'h0, 32'hDE22BE44, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      acc(0, 1'b0, a[i], 32'h0, 4'hF);
      checks++; if (vld0 !== 1'b1 || dout0 !== e[i]) begin errors++; $display("FAIL b2b_%0d got vld=%b dout=%h exp vld=1 dout=%h", i, vld0, dout0, e[i]); end
    end
    step();
    checks++; if (vld0 !== 1'b0 || dout0 !== 32'hCAFEF00D) begin errors++; $display("FAIL hold got vld=%b dout=%h exp vld=0 dout=cafef00d", vld0, dout0); end
  endtask

  task automatic test_cs_high();
    we_n = 1'b0;
    be_n = 4'h0;
    addr = 10'h010;
    din = 32'h0;
    step();
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL cs_high_vld got %b exp 0", vld0); end
    acc(0, 1'b0, 10'h010, 32'h0, 4'hF);
    checks++; if (dout0 !== 32'hDE22BE44) begin errors++; $display("FAIL cs_high_data got %h exp de22be44", dout0); end
  endtask

  task automatic test_out_reg();
    logic [31:0] e [4] = '{32'hX, 32'hA5, 32'hA6, 32'hA7};
    acc(1, 1'b1, 10'd5, 32'hA5, 4'h0);
    acc(1, 1'b1, 10'd6, 32'hA6, 4'h0);
    acc(1, 1'b1, 10'd7, 32'hA7, 4'h0);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) acc(1, 1'b0, 10'(5 + i), 32'h0, 4'hF);
      else step();
      if (i == 0) begin
        checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL oreg_early got vld=%b exp 0", vld1); end
      end else begin
        checks++; if (vld1 !== 1'b1 || dout1 !== e[i]) begin errors++; $display("FAIL oreg_%0d got vld=%b dout=%h exp vld=1 dout=%h", i, vld1, dout1, e[i]); end
      end
    end
    step();
    checks++; if (vld1 !== 1'b0 || dout1 !== 32'hA7) begin errors++; $display("FAIL oreg_hold got vld=%b dout=%h exp vld=0 dout=a7", vld1, dout1); end
  endtask

  task automatic test_range();
    acc(1, 1'b1, 10'd999, 32'h00000999, 4'h0);
    acc(1, 1'b1, 10'd1000, 32'hFFFFFFFF, 4'h0);
    acc(1, 1'b0, 10'd1000, 32'h0, 4'hF);
    step();
    checks++; if (vld1 !== 1'b1 || dout1 !== 32'h0) begin errors++; $display("FAIL range_read got vld=%b dout=%h exp vld=1 dout=0", vld1, dout1); end
    acc(1, 1'b0, 10'd999, 32'h0, 4'hF);
    step();
    checks++; if (vld1 !== 1'b1 || dout1 !== 32'h00000999) begin errors++; $display("FAIL range_999 got vld=%b dout=%h exp vld=1 dout=999", vld1, dout1); end
  endtask

  task automatic test_rst_inflight();
    acc(1, 1'b0, 10'd999, 32'h0, 4'hF);
    rst1 = 1'b1;
    step();
    checks++; if (vld1 !== 1'b0 || dout1 !== 32'h0 || busy1 !== 1'b1) begin errors++; $display("FAIL rst_inflight got vld=%b dout=%h busy=%b exp 0 0 1", vld1, dout1, busy1); end
    rst1 = 1'b0;
    step();
    checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL rst_inflight_late got vld=%b exp 0", vld1); end
  endtask

  task automatic test_busy_ignored();
    int n = 0;
    acc(0, 1'b1, 10'd3, 32'h33333333, 4'h0);
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    acc(0, 1'b1, 10'd3, 32'hFFFFFFFF, 4'h0);
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL busy_write_vld got %b exp 0", vld0); end
    acc(0, 1'b0, 10'd3, 32'h0, 4'hF);
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL busy_read_vld got %b exp 0", vld0); end
    for (int i = 0; i < 498; i++) step();
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (busy0) n++;
      step();
    end
    checks++; if (n != 1024) begin errors++; $display("FAIL refill_len got %0d exp 1024", n); end
    acc(0, 1'b1, 10'd9, 32'h00005A5A, 4'h0);
    acc(0, 1'b0, 10'd9, 32'h0, 4'hF);
    checks++; if (dout0 !== 32'h00005A5A) begin errors++; $display("FAIL refill_addr9 got %h exp 5a5a", dout0); end
    acc(0, 1'b0, 10'd3, 32'h0, 4'hF);
    checks++; if (vld0 !== 1'b1 || dout0 !== 32'h0) begin errors++; $display("FAIL refill_addr3 got vld=%b dout=%h exp vld=1 dout=0", vld0, dout0); end
  endtask

  task automatic test_no_init();
    acc(2, 1'b1, 10'h020, 32'h12345678, 4'h0);
    acc(2, 1'b0, 10'h020, 32'h0, 4'hF);
    checks++; if (dout2 !== 32'h12345678) begin errors++; $display("FAIL noinit_pre got %h exp 12345678", dout2); end
    rst2 = 1'b1;
    step();
    checks++; if (busy2 !== 1'b0 || dout2 !== 32'h0) begin errors++; $display("FAIL noinit_rst got busy=%b dout=%h exp 0 0", busy2, dout2); end
    rst2 = 1'b0;
    step();
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL noinit_busy got %b exp 0", busy2); end
    acc(2, 1'b0, 10'h020, 32'h0, 4'hF);
    checks++; if (vld2 !== 1'b1 || dout2 !== 32'h12345678) begin errors++; $display("FAIL noinit_keep got vld=%b dout=%h exp vld=1 dout=12345678", vld2, dout2); end
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_byte_lanes();
    test_raw();
    test_back_to_back();
    test_cs_high();
    test_out_reg();
    test_range();
    test_rst_inflight();
    test_busy_ignored();
    test_no_init();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_sp.md
RAM_SP -- requirements
Module: ram_sp

Interface
REQ-001 Parameter DATA_W, 32, data word width in bits; SHALL be a multiple of 8 (elaboration error otherwise).
REQ-002 Parameter DEPTH, 1024, number of words; need not be a power of two.
REQ-003 Parameter OUT_REG, 0, 0 = read latency 1 cycle, 1 = extra output register, read latency 2 cycles.
REQ-004 Parameter INIT_ON_RESET, 1, 1 = zero-fill all words after reset, 0 = no fill.
REQ-005 Derived ADDR_W = $clog2(DEPTH), minimum 1; NBYTE = DATA_W/8.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 cs_n  in  1  chip select, active-low.
REQ-009 we_n  in  1  write enable, active-low; 1 with cs_n=0 means read.
REQ-010 be_n  in  NBYTE  byte-lane write enables, active-low, bit i covers din[8i+7:8i].
REQ-011 addr  in  ADDR_W  word address.
REQ-012 din  in  DATA_W  write data.
REQ-013 dout  out  DATA_W  read data, registered.
REQ-014 dout_vld  out  1  one-cycle pulse marking new dout.
REQ-015 busy  out  1  high while zero-fill in progress; accesses ignored.

Function
REQ-016 FSM states: INIT (zero-fill) and READY; reset enters INIT if INIT_ON_RESET=1, else READY.
REQ-017 INIT: fill counter starts at 0, writes all-zero word to address counter each cycle, increments by 1; after writing DEPTH-1 the FSM moves to READY the next cycle.
REQ-018 INIT duration SHALL be exactly DEPTH cycles from the first cycle after rst deasserts; busy=1 throughout, busy=0 in READY.
REQ-019 In INIT, cs_n/we_n/be_n/addr/din SHALL be ignored: no write, no dout_vld.
REQ-020 Write (READY, cs_n=0, we_n=0): at the clock edge, each lane with be_n[i]=0 takes din lane i; lanes with be_n[i]=1 unchanged; all be_n=1 is a no-op.
REQ-021 Read (READY, cs_n=0, we_n=1): array word at addr appears on dout with dout_vld=1 exactly 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles after the request edge.
REQ-022 Back-to-back reads every cycle SHALL produce one dout_vld per request, in order, no bubbles.
REQ-023 Read of an address written on the previous edge SHALL return the new data.
REQ-024 dout SHALL hold its last value while dout_vld=0.
REQ-025 addr >= DEPTH: write dropped; read returns all-zero data with dout_vld asserted at normal latency.
REQ-026 cs_n=1: no array access, no dout_vld, regardless of other inputs.

Reset
REQ-027 rst=1 at a clock edge: dout=0, dout_vld=0, read pipeline valids cleared, fill counter=0, busy=1 if INIT_ON_RESET=1 else 0.
REQ-028 rst during INIT restarts fill from address 0; rst during a read discards the in-flight read (no dout_vld).
REQ-029 Array contents SHALL NOT be cleared by rst itself; with INIT_ON_RESET=0 contents survive reset.

Structure
REQ-030 Package ram_pkg SHALL hold the FSM state enum (INIT, READY) and helper function for read latency from OUT_REG.
REQ-031 One sub-module ram_sp_core: byte-enabled storage array plus first read register, no reset on the array, inferable as block RAM.
REQ-032 ram_sp owns FSM, fill counter, write mux (fill vs user), range check, optional output stage, valid pipeline.

Verification
REQ-033 Defaults, rst 1 cycle then release -> busy=1 for exactly 1024 cycles; then read addr 0x3FF -> dout=0x00000000, dout_vld 1 cycle later.
REQ-034 Write 0xDEADBEEF to 0x010 be_n=0000, then write 0x11223344 be_n=1010 -> read 0x010 returns 0xDE22BE44.
REQ-035 OUT_REG=1: reads to 5, 6, 7 on consecutive cycles after writing 0xA5,0xA6,0xA7 -> dout_vld high 3 consecutive cycles starting 2 cycles after first request, data 0xA5,0xA6,0xA7.
REQ-036 DEPTH=1000: write 0xFFFFFFFF to addr 1000, read 1000 -> dout=0, dout_vld=1; read 999 unaffected.
REQ-037 Write during busy to addr 3 then reset at fill count 500 -> fill restarts at 0, busy lasts full 1024 cycles, addr 3 reads 0.
REQ-038 INIT_ON_RESET=0: write 0x12345678 to 0x020, pulse rst, read 0x020 -> 0x12345678, busy never asserted.
